// File: rtl/counter_checker.sv
// Receive-side checker for an up/down counter stream: predicts the next value, locks onto a
// consistent sequence and counts mismatches once locked. Define COUNTER_CHECKER_STICKY_EN
// to add sticky capture of the first locked mismatch.
module counter_checker #(
   parameter int unsigned W        = 5,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_en,
   input  logic             mode,
   input  logic [W-1:0]     counter,
`ifdef COUNTER_CHECKER_STICKY_EN
   input  logic             clr_sticky,
   output logic             err_sticky,
   output logic [W-1:0]     first_exp,
   output logic [W-1:0]     first_act,
`endif
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt,
   output logic [W-1:0]     expected
);

   localparam int unsigned      GcW      = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
   localparam logic [GcW-1:0]   LastGood = GcW'(LOCK_CNT - 1);
   localparam logic [ERR_W-1:0] ErrMax   = '1;

   typedef enum logic [1:0] {StUnlock, StTrack, StLocked} state_e;

   state_e           state_q, state_d;
   logic [GcW-1:0]   good_cnt_q, good_cnt_d;
   logic             mode_q, mode_d;
   logic             locked_q, locked_d;
   logic             err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [W-1:0]     expected_q, expected_d;
   logic             lock_err;

`ifdef COUNTER_CHECKER_STICKY_EN
   logic             sticky_q, sticky_d;
   logic [W-1:0]     first_exp_q, first_exp_d;
   logic [W-1:0]     first_act_q, first_act_d;
`endif

   function automatic logic [W-1:0] next_val(input logic [W-1:0] v, input logic m);
      return m ? v - W'(1) : v + W'(1);
   endfunction

   always_comb begin
      state_d     = state_q;
      good_cnt_d  = good_cnt_q;
      mode_d      = mode;
      err_cnt_d   = err_cnt_q;
      expected_d  = expected_q;
      lock_err    = 1'b0;

      if (sample_en) begin
         // Always resync the prediction to what was actually observed.
         expected_d = next_val(counter, mode);
         if (mode == mode_q) begin
            case (state_q)
               StUnlock: begin
                  state_d    = StTrack;
                  good_cnt_d = '0;
               end
               StTrack: begin
                  if (counter == expected_q) begin
                     if (good_cnt_q == LastGood) begin
                        state_d    = StLocked;
                        good_cnt_d = '0;
                     end else begin
                        good_cnt_d = good_cnt_q + GcW'(1);
                     end
                  end else begin
                     good_cnt_d = '0;
                  end
               end
               StLocked: begin
                  if (counter != expected_q) begin
                     lock_err   = 1'b1;
                     state_d    = StTrack;
                     good_cnt_d = '0;
                     if (err_cnt_q != ErrMax) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                     end
                  end
               end
               default: begin
                  state_d    = StUnlock;
                  good_cnt_d = '0;
               end
            endcase
         end
      end

      locked_d    = (state_d == StLocked);
      err_pulse_d = lock_err;
   end

`ifdef COUNTER_CHECKER_STICKY_EN
   // Capture takes priority over a simultaneous clear.
   always_comb begin
      sticky_d    = sticky_q;
      first_exp_d = first_exp_q;
      first_act_d = first_act_q;
      if (lock_err && !sticky_q) begin
         sticky_d    = 1'b1;
         first_exp_d = expected_q;
         first_act_d = counter;
      end else if (clr_sticky) begin
         sticky_d    = 1'b0;
         first_exp_d = '0;
         first_act_d = '0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StUnlock;
         good_cnt_q  <= '0;
         mode_q      <= 1'b0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
         expected_q  <= '0;
`ifdef COUNTER_CHECKER_STICKY_EN
         sticky_q    <= 1'b0;
         first_exp_q <= '0;
         first_act_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         good_cnt_q  <= good_cnt_d;
         mode_q      <= mode_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_cnt_q   <= err_cnt_d;
         expected_q  <= expected_d;
`ifdef COUNTER_CHECKER_STICKY_EN
         sticky_q    <= sticky_d;
         first_exp_q <= first_exp_d;
         first_act_q <= first_act_d;
`endif
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;
   assign expected  = expected_q;

`ifdef COUNTER_CHECKER_STICKY_EN
   assign err_sticky = sticky_q;
   assign first_exp  = first_exp_q;
   assign first_act  = first_act_q;
`endif

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receive-side monitor for the 5-bit synchronous up/down counter.
- Samples the counter value plus its mode, predicts the next value, locks onto a valid sequence, and flags and counts sequence errors once locked.
- Sits beside the counter in block-level benches and on-chip debug paths as the consumer ("reader") of the counter stream.

Parameters:
W, 5, width of observed counter value
LOCK_CNT, 4, consecutive matching samples required to declare lock (≥1)
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
sample_en  input  1  counter value valid this cycle
mode  input  1  counter mode: 0 = increment, 1 = decrement
counter  input  W  observed counter value
locked  output  1  sequence locked
err_pulse  output  1  one-cycle mismatch strobe
err_cnt  output  ERR_W  saturating mismatch count
expected  output  W  predicted next value

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state UNLOCK; locked 0; err_pulse 0; err_cnt 0; expected 0; good_cnt 0; mode_q 0. Assertion mid-operation clears all of these immediately, with no clock edge needed.
- next(v,m): m=0 gives (v+1) mod 2^W; m=1 gives (v−1) mod 2^W. So 2^W−1 → 0 going up, and 0 → 2^W−1 going down.
- mode_q: registers mode every cycle, regardless of sample_en.
- A "sample" is a rising edge with sample_en=1. Cycles with sample_en=0 change nothing except mode_q. err_pulse is 0 in any cycle not following a LOCKED mismatch.
- Every sample loads expected <= next(counter, mode), so the checker always resyncs to the observed value.
- Mode change: a sample with mode ≠ mode_q skips the compare. State and good_cnt are unchanged and no error is raised; expected still reloads.
- FSM, on a sample with no mode change:
  - UNLOCK: go to TRACK; good_cnt <= 0.
  - TRACK, counter == expected: good_cnt++. If good_cnt+1 == LOCK_CNT, go to LOCKED and clear good_cnt.
  - TRACK, mismatch: good_cnt <= 0; stay in TRACK; no error reported.
  - LOCKED, match: stay.
  - LOCKED, mismatch: err_pulse <= 1 for exactly one cycle; err_cnt increments, saturating at 2^ERR_W−1; go to TRACK; good_cnt <= 0.
- Output timing:
  - locked = (state == LOCKED), registered.
  - locked and err_pulse are visible in the cycle after the deciding edge (latency 1).
- Back-to-back mismatches: after a mismatch in LOCKED, further mismatches fall in TRACK and do not count. At most one error is counted per lock episode.

Optional Feature:
- Macro: COUNTER_CHECKER_STICKY_EN.
- When defined, adds these ports:
  - clr_sticky (input, 1)
  - err_sticky (output, 1)
  - first_exp (output, W)
  - first_act (output, W)
- On the first LOCKED mismatch while err_sticky=0:
  - err_sticky <= 1
  - first_exp <= expected
  - first_act <= counter
- These hold until rst_n or clr_sticky=1 at a clock edge, which clears all three to 0.
- If clr_sticky and a qualifying mismatch occur on the same edge, capture wins.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then mode=0, samples 0,1,2,3,4 on consecutive edges -> locked=1 in the cycle after the edge sampling 4; err_cnt=0; expected=5.
2. Locked, mode=0, samples 30,31,0,1 -> no err_pulse, locked stays 1, expected=2 (up-wrap). Repeat with mode=1, samples 1,0,31,30 -> no error, expected=29 (down-wrap).
3. Locked, mode=0, samples 7 then 9 -> err_pulse high for one cycle after the 9 edge; err_cnt=1; locked=0. Then samples 10,11,12,13 -> locked=1 again. With STICKY_EN: err_sticky=1, first_exp=8, first_act=9.
4. Locked, mode=0, samples 10,11; then mode=1 with sample 12; then samples 11,10 -> no err_pulse, locked stays 1, expected=9. sample_en=0 gaps inserted between samples change nothing.
5. Locked with err_cnt=3, rst_n low mid-cycle -> locked, err_pulse, err_cnt and expected go to 0 asynchronously, before the next edge. Release rst_n -> state UNLOCK.
6. ERR_W=2, five lock-then-mismatch episodes -> err_cnt reads 1,2,3,3,3 (saturates); five err_pulses observed.
